// File: rtl/decoder_3to8_seq.sv
// decoder_3to8_seq
//   Sequenced 3-to-8 one-hot decoder. 3-bit codes arrive over a valid/ready
//   handshake and are queued in a small circular FIFO. Each code is played out
//   as a one-hot byte held for HOLD_CYCLES cycles, then GAP_CYCLES all-zero
//   cycles. Every non-zero output word is a legal input to the 8-to-3 encoder.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   in_valid    command present on in_data
//   in_ready    FIFO not full (independent of a same-cycle pop)
//   in_data     3-bit code, bit 0 = LSB
//   out_data    registered one-hot word during DRIVE, 8'h00 otherwise
//   out_valid   high while in DRIVE (out_data non-zero)
//   done        one-cycle pulse on the last GAP cycle of each command
//   busy        FSM not idle or FIFO not empty
//   fifo_count  current FIFO occupancy
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | output zero, waiting for a queued code
// ST_DRIVE | one-hot word held on out_data, hold timer counting down
// ST_GAP   | output zero, gap timer counting down; done on last cycle

module decoder_3to8_seq #(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [2:0]                         in_data,
    output logic [7:0]                         out_data,
    output logic                               out_valid,
    output logic                               done,
    output logic                               busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int MAX_C = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    // Timer only has to hold max(HOLD, GAP) - 1.
    localparam int TMR_W = (MAX_C > 1) ? $clog2(MAX_C) : 1;
    localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD  = TMR_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [7:0]         out_data_q, out_data_d;
    logic [2:0]         mem_q [FIFO_DEPTH];
    logic [2:0]         mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               fifo_empty;
    logic               wr_en;
    logic               pop;
    logic [2:0]         head_code;

    assign fifo_empty = (count_q == '0);
    // Full refuses writes even when a pop lands on the same edge.
    assign in_ready   = (count_q != CNT_W'(FIFO_DEPTH));
    assign wr_en      = in_valid && in_ready;
    assign head_code  = mem_q[rd_ptr_q];

    // Sequencer next state
    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q;
        out_data_d = out_data_q;
        pop        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                out_data_d = 8'h00;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    out_data_d = 8'h01 << head_code;
                    tmr_d      = HOLD_LOAD;
                    state_d    = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (tmr_q == '0) begin
                    out_data_d = 8'h00;
                    tmr_d      = GAP_LOAD;
                    state_d    = ST_GAP;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            ST_GAP: begin
                if (tmr_q == '0) begin
                    // Back-to-back: go straight to DRIVE without an IDLE cycle.
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        out_data_d = 8'h01 << head_code;
                        tmr_d      = HOLD_LOAD;
                        state_d    = ST_DRIVE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            default: begin
                out_data_d = 8'h00;
                state_d    = ST_IDLE;
            end
        endcase
    end

    // FIFO next state; pointers wrap naturally since depth is a power of 2.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = in_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({wr_en, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            tmr_q      <= '0;
            out_data_q <= 8'h00;
            mem_q      <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            out_data_q <= out_data_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = (state_q == ST_DRIVE);
    assign done       = (state_q == ST_GAP) && (tmr_q == '0);
    assign busy       = (state_q != ST_IDLE) || !fifo_empty;
    assign fifo_count = count_q;

endmodule
